// File: rtl/mem_arbiter_if.sv
// Two-port memory arbiter bus: requester handshakes, burst lock, memory strobes
// and the contention counter, grouped so the arbiter takes a single port.
interface mem_arbiter_if;
    logic        req0;
    logic        req1;
    logic        we0;
    logic        we1;
    logic [12:0] addr0;
    logic [12:0] addr1;
    logic [7:0]  wdata0;
    logic [7:0]  wdata1;
    logic        lock1;
    logic        gnt0;
    logic        gnt1;
    logic        rvalid0;
    logic        rvalid1;
    logic [7:0]  rdata;
    logic [12:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_rdata;
    logic [7:0]  conflicts;

    // Arbiter side.
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock1, mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, mem_addr, mem_wdata, mem_rd, mem_wr,
               conflicts
    );

    // Requester and memory side.
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock1, mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, mem_addr, mem_wdata, mem_rd, mem_wr,
               conflicts
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port single-memory arbiter: CPU (port 0) and loader/DMA (port 1) share one
// byte-wide memory through an IDLE -> ACCESS -> (RESP) -> IDLE sequence.
module mem_arbiter (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    state_e      state_q, state_d;
    logic        gnt0_q, gnt0_d;
    logic        gnt1_q, gnt1_d;
    logic        rvalid0_q, rvalid0_d;
    logic        rvalid1_q, rvalid1_d;
    logic        mem_rd_q, mem_rd_d;
    logic        mem_wr_q, mem_wr_d;
    logic [12:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic [7:0]  conflicts_q, conflicts_d;
    logic        last_gnt_q, last_gnt_d;   // 1 = port 1 was granted last

    logic        contended;
    logic        win1;
    logic        win_we;

    // Winner selection: lock1 only matters when both ports request.
    always_comb begin
        contended = bus.req0 & bus.req1;
        if (contended) begin
            win1 = bus.lock1 | ~last_gnt_q;
        end else begin
            win1 = bus.req1;
        end
        win_we = win1 ? bus.we1 : bus.we0;
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        rvalid0_d   = 1'b0;
        rvalid1_d   = 1'b0;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        conflicts_d = conflicts_q;
        last_gnt_d  = last_gnt_q;

        unique case (state_q)
            IDLE: begin
                if (contended && conflicts_q != 8'hFF) begin
                    conflicts_d = conflicts_q + 8'd1;
                end
                if (bus.req0 || bus.req1) begin
                    state_d     = ACCESS;
                    last_gnt_d  = win1;
                    gnt0_d      = ~win1;
                    gnt1_d      = win1;
                    mem_rd_d    = ~win_we;
                    mem_wr_d    = win_we;
                    mem_addr_d  = win1 ? bus.addr1 : bus.addr0;
                    mem_wdata_d = win1 ? bus.wdata1 : bus.wdata0;
                end
            end
            ACCESS: begin
                // The registered grant already identifies who gets the read data.
                if (mem_rd_q) begin
                    state_d   = RESP;
                    rvalid0_d = gnt0_q;
                    rvalid1_d = gnt1_q;
                end else begin
                    state_d = IDLE;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            conflicts_q <= '0;
            last_gnt_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            conflicts_q <= conflicts_d;
            last_gnt_q  <= last_gnt_d;
        end
    end

    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.rvalid0   = rvalid0_q;
    assign bus.rvalid1   = rvalid1_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.conflicts = conflicts_q;
    assign bus.rdata     = bus.mem_rdata;
endmodule
